// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard that stalls ID on RAW hazards and gates IF flush.
// Optional HAZARD_STATS_EN adds saturating StallCount/FlushCount outputs.
module hazard_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int REG_AW    = 5,
    parameter int ALU_LAT   = 0,
    parameter int LOAD_LAT  = 1,
    parameter int MULTI_LAT = 2,
    parameter int BR_EXTRA  = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ID_Valid,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic              ID_IsBranch,
    input  logic [REG_AW-1:0] ID_Dst,
    input  logic              ID_DstWrite,
    input  logic [1:0]        ID_Class,
    input  logic              PCSRC,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              IDStall,
    output logic              IF_Flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]       StallCount,
    output logic [15:0]       FlushCount
`endif
);
    localparam int CW = $clog2(MULTI_LAT + BR_EXTRA + 1);

    logic [CW-1:0] cnt [NUM_REGS];
    logic [CW-1:0] thresh;
    logic [CW-1:0] load_val;
    logic          pend_rs;
    logic          pend_rt;
    logic          stall;
    logic          issue;

    // Non-branch consumers get forwarding, so they only wait while more than BR_EXTRA cycles remain.
    always_comb begin
        thresh    = ID_IsBranch ? '0 : CW'(BR_EXTRA);
        pend_rs   = ID_UsesRs && ID_Rs != '0 && cnt[ID_Rs] > thresh;
        pend_rt   = ID_UsesRt && ID_Rt != '0 && cnt[ID_Rt] > thresh;
        stall     = Rst_n && ID_Valid && (pend_rs || pend_rt);
        issue     = ID_Valid && !stall;
        load_val  = ID_Class == 2'd1 ? CW'(LOAD_LAT + BR_EXTRA) :
                    ID_Class == 2'd2 ? CW'(MULTI_LAT + BR_EXTRA) : CW'(ALU_LAT + BR_EXTRA);
        PCWrite   = !stall;
        IFIDWrite = !stall;
        IDStall   = stall;
        IF_Flush  = Rst_n && !stall && PCSRC;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= (issue && ID_DstWrite && ID_Dst != '0 && ID_Dst == REG_AW'(r)) ? load_val :
                          (cnt[r] != '0) ? cnt[r] - 1'b1 : cnt[r];
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (IDStall && StallCount != 16'hFFFF) StallCount <= StallCount + 1'b1;
            if (IF_Flush && FlushCount != 16'hFFFF) FlushCount <= FlushCount + 1'b1;
        end
    end
`endif
endmodule
